// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: widths, controller state encoding and
// the small GF(2^8) / word helpers used by the round-key sequencer.
package aes_pkg;

    localparam int BYTE    = 8;
    localparam int DWORD   = 32;
    localparam int LENGTH  = 128;
    localparam int NROUNDS = 10;
    localparam int IDX_W   = 4;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NROUNDS);
    localparam logic [BYTE-1:0]  RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        CALC = 2'd2,
        FIN  = 2'd3
    } state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [DWORD-1:0] rot_word(input logic [DWORD-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/key_sched_ctrl_subword.sv
// AES SubWord: four forward S-box lookups applied in parallel, purely combinational.
module key_sched_ctrl_subword
    import aes_pkg::*;
(
    input  logic [DWORD-1:0] word_i,
    output logic [DWORD-1:0] word_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte-parallel S-box substitution.
    always_comb begin
        word_o = {DWORD{1'b0}};
        for (int b = 0; b < DWORD / BYTE; b++) begin
            word_o[b*BYTE +: BYTE] = SBOX[word_i[b*BYTE +: BYTE]];
        end
    end

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 key-expansion sequencer: derives rk0..rk10 one round at a time and
// streams each round key over a valid/ready handshake.
module key_sched_ctrl
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LENGTH-1:0] key_in,
    output logic              busy,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [LENGTH-1:0] rk_out,
    output logic [IDX_W-1:0]  rk_idx,
    output logic              done
);

    state_e             state_q, state_d;
    logic [LENGTH-1:0]  key_q, key_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BYTE-1:0]    rcon_q, rcon_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic [DWORD-1:0]   w0_s, w1_s, w2_s, w3_s;
    logic [DWORD-1:0]   sub_in_s, sub_out_s, temp_s;
    logic [DWORD-1:0]   nw0_s, nw1_s, nw2_s, nw3_s;

    assign w0_s = key_q[127:96];
    assign w1_s = key_q[95:64];
    assign w2_s = key_q[63:32];
    assign w3_s = key_q[31:0];

    assign sub_in_s = rot_word(w3_s);

    key_sched_ctrl_subword u_subword (
        .word_i (sub_in_s),
        .word_o (sub_out_s)
    );

    // Next round key is a running XOR chain seeded by the transformed last word.
    assign temp_s = sub_out_s ^ {rcon_q, 24'h000000};
    assign nw0_s  = w0_s ^ temp_s;
    assign nw1_s  = w1_s ^ nw0_s;
    assign nw2_s  = w2_s ^ nw1_s;
    assign nw3_s  = w3_s ^ nw2_s;

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EMIT;
                    key_d   = key_in;
                    idx_d   = {IDX_W{1'b0}};
                    rcon_d  = RCON_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = FIN;
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            CALC: begin
                state_d = EMIT;
                key_d   = {nw0_s, nw1_s, nw2_s, nw3_s};
                idx_d   = idx_q + 4'd1;
                rcon_d  = xtime(rcon_q);
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status flags are registered from the upcoming state so they align with it.
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == EMIT);
        done_d  = (state_d == FIN);
    end

    // State, key, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= {LENGTH{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            rcon_q  <= RCON_INIT;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign rk_valid = valid_q;
    assign rk_out   = key_q;
    assign rk_idx   = idx_q;
    assign done     = done_q;

endmodule
